// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite constants, the SRAM slave FSM state type and the byte-enable helper.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {StIdle, StRwait, StErr1, StErr2} spram_state_e;

    // Oversized transfers clamp to all lanes; misaligned ones align down to their size.
    function automatic logic [15:0] gen_be(input logic [2:0] hsize, input logic [3:0] haddr,
                                           input int unsigned xlen);
        int unsigned lanes;
        int unsigned nbytes;
        int unsigned off;
        logic [31:0] m;
        lanes  = xlen / 8;
        nbytes = 32'd1 << hsize;
        if (nbytes > lanes) nbytes = lanes;
        off = 32'(haddr) & (lanes - 1) & ~(nbytes - 1);
        m   = ((32'd1 << nbytes) - 32'd1) << off;
        return m[15:0];
    endfunction

endpackage

// File: rtl/peripheral_spram_ahb3_ws_if.sv
// AHB3-Lite slave port bundle for the wait-state SRAM slave.
interface peripheral_spram_ahb3_ws_if #(
    parameter int unsigned PLEN = 32,
    parameter int unsigned XLEN = 32
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/peripheral_spram_1r1w.sv
// One read / one write port SRAM with registered read data and byte-lane write enables.
module peripheral_spram_1r1w #(
    parameter int unsigned ABITS      = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DBITS      = 32,
    parameter string       TECHNOLOGY = "GENERIC"
) (
    input  logic               clk,
    input  logic               re,
    input  logic [ABITS-1:0]   raddr,
    output logic [DBITS-1:0]   dout,
    input  logic               we,
    input  logic [ABITS-1:0]   waddr,
    input  logic [DBITS/8-1:0] be,
    input  logic [DBITS-1:0]   din
);
    logic [DBITS-1:0] mem_q [DEPTH];
    logic [DBITS-1:0] dout_q;

    // Read and write on the same edge return the old contents; the caller forwards.
    always_ff @(posedge clk) begin
        if (re) dout_q <= mem_q[raddr];
        if (we) begin
            for (int i = 0; i < int'(DBITS / 8); i++) begin
                if (be[i]) mem_q[waddr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/peripheral_spram_ahb3_ws.sv
// AHB3-Lite SRAM slave with programmable read wait states and write-to-read byte forwarding.
// Define PERIPHERAL_SPRAM_AHB3_ERR_EN to answer illegal accesses with a two-cycle ERROR.
module peripheral_spram_ahb3_ws
    import peripheral_ahb3_pkg::*;
#(
    parameter int unsigned PLEN       = 32,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RD_WAIT    = 0,
    parameter string       TECHNOLOGY = "GENERIC"
) (
    input logic                      HCLK,
    input logic                      HRESETn,
    peripheral_spram_ahb3_ws_if.slave ahb
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned BOFF  = $clog2(BE_W);
    localparam int unsigned ABITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WBITS = PLEN - BOFF;

    spram_state_e     state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             hreadyout, hresp;
    logic             acc, acc_ok, err, fwd_hit;
    logic [WBITS-1:0] word;
    logic [ABITS-1:0] widx;
    logic [BE_W-1:0]  be;
    logic             wr_pend_q;
    logic [ABITS-1:0] wr_idx_q;
    logic [BE_W-1:0]  wr_be_q, byp_be_q;
    logic             rd_dp_q;
    logic [XLEN-1:0]  byp_data_q, hrdata_q, mem_dout, rd_merged;
    logic             unused_sig;

    assign acc    = ahb.HSEL & ahb.HREADY &
                    ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));
    assign word   = ahb.HADDR[PLEN-1:BOFF];
    assign widx   = ABITS'(word % WBITS'(MEM_DEPTH));
    assign be     = BE_W'(gen_be(ahb.HSIZE, ahb.HADDR[3:0], XLEN));
    assign acc_ok = acc & ~err;

`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
    logic misaligned;
    assign misaligned = |(32'(ahb.HADDR[BOFF-1:0]) & ((32'd1 << ahb.HSIZE) - 32'd1));
    assign err = acc & ((32'(ahb.HSIZE) > BOFF) | misaligned | (word >= WBITS'(MEM_DEPTH)));
    assign ahb.HRESP = hresp;
    assign unused_sig = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};
`else
    assign err = 1'b0;
    assign ahb.HRESP = HRESP_OKAY;
    assign unused_sig = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, hresp};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (state_q)
            StIdle, StErr2: begin
                if (state_q == StErr2) hresp = HRESP_ERROR;
                state_d = StIdle;
                if (err) begin
                    state_d = StErr1;
                end else if (acc && !ahb.HWRITE && RD_WAIT != 0) begin
                    state_d = StRwait;
                    cnt_d   = 2'(RD_WAIT - 1);
                end
            end
            StRwait: begin
                hreadyout = 1'b0;
                if (cnt_q == 2'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 2'd1;
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A read address phase overlapping the data phase of a write to the same word.
    assign fwd_hit = wr_pend_q & (wr_idx_q == widx);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            wr_be_q    <= '0;
            rd_dp_q    <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
            hrdata_q   <= '0;
        end else begin
            wr_pend_q <= acc_ok & ahb.HWRITE;
            if (acc_ok & ahb.HWRITE) begin
                wr_idx_q <= widx;
                wr_be_q  <= be;
            end
            if (rd_dp_q & hreadyout) hrdata_q <= rd_merged;
            if (acc_ok & ~ahb.HWRITE) begin
                rd_dp_q    <= 1'b1;
                byp_be_q   <= fwd_hit ? wr_be_q : '0;
                byp_data_q <= ahb.HWDATA;
            end else if (hreadyout) begin
                rd_dp_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_merged = mem_dout;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (byp_be_q[i]) rd_merged[8*i +: 8] = byp_data_q[8*i +: 8];
        end
    end

    assign ahb.HRDATA    = rd_dp_q ? rd_merged : hrdata_q;
    assign ahb.HREADYOUT = hreadyout;

    peripheral_spram_1r1w #(
        .ABITS      (ABITS),
        .DEPTH      (MEM_DEPTH),
        .DBITS      (XLEN),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_ram (
        .clk   (HCLK),
        .re    (acc_ok & ~ahb.HWRITE),
        .raddr (widx),
        .dout  (mem_dout),
        .we    (wr_pend_q),
        .waddr (wr_idx_q),
        .be    (wr_be_q),
        .din   (ahb.HWDATA)
    );

endmodule

// File: tb/tb_peripheral_spram_ahb3_ws.sv
// Directed bench for peripheral_spram_ahb3_ws (RD_WAIT=2) with a read-data scoreboard.
module tb_peripheral_spram_ahb3_ws;
    import peripheral_ahb3_pkg::*;

    localparam int unsigned RdWait   = 2;
    localparam int unsigned MemDepth = 256;

    typedef struct {
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          chk_data;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    peripheral_spram_ahb3_ws_if #(.PLEN(32), .XLEN(32)) ahb ();
    assign ahb.HREADY = ahb.HREADYOUT;

    peripheral_spram_ahb3_ws #(
        .PLEN       (32),
        .XLEN       (32),
        .MEM_DEPTH  (MemDepth),
        .RD_WAIT    (RdWait),
        .TECHNOLOGY ("GENERIC")
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (ahb.slave)
    );

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] model [MemDepth];
    logic [31:0] nxt_wdata;
    logic        dp_rd;
    int          waits_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bench-side view of whether a read data phase is in progress.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)        dp_rd <= 1'b0;
        else if (ahb.HREADY) dp_rd <= ahb.HSEL && ahb.HTRANS[1] && !ahb.HWRITE;
    end

    always @(negedge HCLK) begin
        if (!dp_rd) begin
            waits_seen <= 0;
        end else if (!ahb.HREADYOUT) begin
            waits_seen <= waits_seen + 1;
        end else begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                if (sbq[0].chk_data) check("rd_data", ahb.HRDATA, sbq[0].data);
                check("rd_resp", 32'(ahb.HRESP), 32'(sbq[0].resp));
                check("rd_waits", 32'(waits_seen), 32'(sbq[0].waits));
                sbq.delete(0);
            end
            waits_seen <= 0;
        end
    end

    task automatic bus(input bit sel, input logic [1:0] trans, input bit wr,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        bit rdy;
        int guard;
        ahb.HSEL   = sel;
        ahb.HTRANS = trans;
        ahb.HWRITE = wr;
        ahb.HADDR  = addr;
        ahb.HSIZE  = size;
        ahb.HWDATA = wdata;
        rdy   = 1'b0;
        guard = 0;
        while (!rdy && guard < 16) begin
            @(negedge HCLK);
            rdy = ahb.HREADY;
            @(posedge HCLK);
            guard++;
        end
        if (!rdy) check("hready_timeout", 32'(rdy), 32'd1);
        #1;
    endtask

    task automatic op_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
        int n;
        int off;
        int idx;
        bus(1'b1, HTRANS_NONSEQ, 1'b1, addr, size, nxt_wdata);
        nxt_wdata = d;
        n   = 1 << size;
        off = int'(addr[1:0]) & ~(n - 1);
        idx = int'((addr >> 2) % MemDepth);
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + n) model[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic op_rd_exp(input logic [31:0] addr, input logic [31:0] exp);
        sbq.push_back('{data: exp, resp: HRESP_OKAY, waits: RdWait, chk_data: 1'b1});
        bus(1'b1, HTRANS_NONSEQ, 1'b0, addr, HSIZE_WORD, nxt_wdata);
        nxt_wdata = 32'h0;
    endtask

    task automatic op_rd(input logic [31:0] addr);
        op_rd_exp(addr, model[int'((addr >> 2) % MemDepth)]);
    endtask

    task automatic op_idle();
        bus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, nxt_wdata);
        nxt_wdata = 32'h0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 20) begin
            op_idle();
            g++;
        end
        if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic chk_okay(input string tag);
        @(negedge HCLK);
        check({tag, "_ready"}, 32'(ahb.HREADYOUT), 32'd1);
        check({tag, "_resp"}, 32'(ahb.HRESP), 32'd0);
    endtask

    initial begin
        ahb.HSEL = 1'b0;   ahb.HTRANS = HTRANS_IDLE; ahb.HWRITE = 1'b0;
        ahb.HADDR = '0;    ahb.HSIZE = HSIZE_WORD;   ahb.HWDATA = '0;
        ahb.HBURST = '0;   ahb.HPROT = '0;           ahb.HMASTLOCK = 1'b0;
        nxt_wdata = 32'h0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        check("rst_hresp", 32'(ahb.HRESP), 32'd0);
        check("rst_hrdata", ahb.HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Write then read through memory, and write then immediate read (forwarded).
        op_wr(32'h10, HSIZE_WORD, 32'hDEADBEEF);
        op_idle();
        op_rd(32'h10);
        op_wr(32'h14, HSIZE_WORD, 32'h01234567);
        op_rd(32'h14);
        drain();

        // Byte write merged into the immediately following read.
        op_wr(32'h20, HSIZE_WORD, 32'h11223344);
        op_wr(32'h21, HSIZE_BYTE, 32'h0000AA00);
        op_rd_exp(32'h20, 32'h1122AA44);
        op_idle();
        op_rd_exp(32'h20, 32'h1122AA44);
        drain();

        // IDLE and BUSY while selected: OKAY, zero wait, no write.
        bus(1'b1, HTRANS_IDLE, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
        chk_okay("idle");
        bus(1'b1, HTRANS_BUSY, 1'b1, 32'h10, HSIZE_WORD, 32'hFFFFFFFF);
        chk_okay("busy");
        bus(1'b1, HTRANS_IDLE, 1'b0, 32'h10, HSIZE_WORD, 32'hFFFFFFFF);
        op_rd(32'h10);
        drain();

        // Sub-word writes, write->write, read->read and read->write back to back.
        op_wr(32'h30, HSIZE_WORD, 32'hA5A5A5A5);
        op_wr(32'h32, HSIZE_HWORD, 32'hBEEF0000);
        op_wr(32'h30, HSIZE_BYTE, 32'h0000007E);
        op_rd_exp(32'h30, 32'hBEEFA57E);
        op_rd(32'h20);
        op_wr(32'h30, HSIZE_WORD, 32'h13572468);
        op_rd(32'h30);
        drain();

        for (int i = 0; i < 8; i++) op_wr(32'h100 + 32'(4 * i), HSIZE_WORD, $urandom);
        for (int i = 0; i < 8; i++) op_rd(32'h100 + 32'(4 * i));
        drain();

        // Access one word past the end of memory.
        op_wr(32'h0, HSIZE_WORD, 32'hCAFEF00D);
        op_idle();
`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
        sbq.push_back('{data: 32'h0, resp: HRESP_ERROR, waits: 1, chk_data: 1'b0});
        bus(1'b1, HTRANS_NONSEQ, 1'b0, MemDepth * 4, HSIZE_WORD, nxt_wdata);
`else
        op_rd_exp(MemDepth * 4, 32'hCAFEF00D);
`endif
        drain();

        // Reset asserted while the read is held in wait states.
        op_idle();
        bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        ahb.HSEL = 1'b0; ahb.HTRANS = HTRANS_IDLE;
        #2;
        check("rwait_hreadyout", 32'(ahb.HREADYOUT), 32'd0);
        HRESETn = 1'b0;
        #1;
        check("rst_rwait_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        check("rst_rwait_hresp", 32'(ahb.HRESP), 32'd0);
        check("rst_rwait_hrdata", ahb.HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Reset between a write's address phase and its commit discards the write.
        bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h30, HSIZE_WORD, 32'h0);
        ahb.HSEL = 1'b0; ahb.HTRANS = HTRANS_IDLE; ahb.HWDATA = 32'hBAD0BAD0;
        #2;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        nxt_wdata = 32'h0;
        op_rd(32'h30);
        op_rd(32'h10);
        drain();

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
